// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the microcoded CPU sequencer:
//   - opcode prefixes the sequencer decodes to resolve the next PC
//   - bit positions of the microinstruction ROM fields
//   - the sequencer state enum
// No ports; imported by uinstr_sequencer and ret_stack.
package cpu_pkg;

    // Conditional/unconditional jump opcodes live in instruction[21:19]
    localparam logic [2:0]  OP_JUMP = 3'b100;
    localparam logic [2:0]  OP_JZE  = 3'b101;
    localparam logic [2:0]  OP_JNE  = 3'b110;
    localparam logic [2:0]  OP_JCY  = 3'b111;

    // Subroutine call is identified by instruction[21:10]
    localparam logic [11:0] OP_BSR  = 12'h700;

    // Return is a single full-width encoding
    localparam logic [21:0] OP_RET  = 22'h060000;

    // Microinstruction field positions
    localparam int ALU_HI    = 32;
    localparam int ALU_LO    = 29;
    localparam int SH_HI     = 28;
    localparam int SH_LO     = 27;
    localparam int KMX_BIT   = 26;
    localparam int MR_BIT    = 25;
    localparam int MW_BIT    = 24;
    localparam int BUSB_HI   = 23;
    localparam int BUSB_LO   = 18;
    localparam int BUSC_HI   = 17;
    localparam int BUSC_LO   = 12;
    localparam int TWORD_HI  = 11;
    localparam int TWORD_LO  = 5;
    localparam int BUSA_HI   = 4;
    localparam int BUSA_LO   = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT_I,
        ST_DECODE,
        ST_EXEC,
        ST_MEM
    } state_t;

endpackage

// File: rtl/ret_stack.sv
// ret_stack
// LIFO of return addresses for BSR/RET.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (empties the stack)
//   push, pop    : push push_data / discard top entry (ignored when full / empty)
//   push_data    : address to save
//   top          : most recently pushed entry (undefined content when empty)
//   full, empty  : occupancy status
module ret_stack
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] sp;
    logic [IDX_W-1:0] top_idx;

    assign full    = (sp == PTR_W'(DEPTH));
    assign empty   = (sp == '0);
    // The low bits of sp wrap to 0 when full, so sp-1 still lands on the last slot
    assign top_idx = sp[IDX_W-1:0] - IDX_W'(1);
    assign top     = mem[top_idx];

    // Stack pointer counts occupied entries; only it needs resetting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + PTR_W'(1);
        end else if (pop && !empty) begin
            sp <= sp - PTR_W'(1);
        end
    end

    // Entry storage; content below sp is never read, so no reset is needed
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[sp[IDX_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/uinstr_sequencer.sv
// uinstr_sequencer
// Fetch/decode/execute sequencer for the microcoded CPU.
// Ports:
//   clk, rst_n          : clock (posedge logic), asynchronous active-low reset
//   run                 : start/continue fetching
//   imem_req/addr       : program memory request and address (= pc)
//   imem_valid/data     : program memory response
//   instruction         : instruction register driven to the microinstruction ROM
//   HOLD                : low only in DECODE, lets the ROM update
//   micro_instruction   : ROM output; only MR/MW are used here
//   flag_z, flag_cy     : datapath flags, sampled in EXEC
//   dmem_req/ack        : data memory handshake for MR/MW instructions
//   pc                  : program counter
//   stack_err           : sticky return-stack overflow/underflow
module uinstr_sequencer
    import cpu_pkg::*;
#(
    parameter int PC_W        = 11,
    parameter int STACK_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [21:0]     imem_data,
    output logic [21:0]     instruction,
    output logic            HOLD,
    input  logic [32:0]     micro_instruction,
    input  logic            flag_z,
    input  logic            flag_cy,
    output logic            dmem_req,
    input  logic            dmem_ack,
    output logic [PC_W-1:0] pc,
    output logic            stack_err
);

    state_t state, next_state;

    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] jump_target;
    logic [PC_W-1:0] bsr_target;
    logic [PC_W-1:0] stack_top;
    logic [2:0]      opcode;
    logic            is_bsr;
    logic            is_ret;
    logic            is_mem;
    logic            in_exec;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    logic            err_event;
    logic            unused_fields;

    assign imem_addr   = pc;
    assign in_exec     = (state == ST_EXEC);
    assign opcode      = instruction[21:19];
    assign is_bsr      = (instruction[21:10] == OP_BSR);
    assign is_ret      = (instruction == OP_RET);
    assign is_mem      = micro_instruction[MR_BIT] | micro_instruction[MW_BIT];
    assign pc_inc      = pc + PC_W'(1);
    assign jump_target = PC_W'(instruction[10:0]);
    assign bsr_target  = PC_W'(instruction[9:0]);

    // Fields the datapath consumes but the sequencer does not
    assign unused_fields = ^{micro_instruction[32:26], micro_instruction[23:0]};

    // Stack operations happen only in EXEC; overflow/underflow skip the access
    assign push      = in_exec && is_bsr && !full;
    assign pop       = in_exec && is_ret && !empty;
    assign err_event = in_exec && ((is_bsr && full) || (is_ret && empty));

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (PC_W)
    ) u_ret_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top       (stack_top),
        .full      (full),
        .empty     (empty)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs; all outputs are pure functions of state
    // so reset drives them to their idle values without waiting for a clock
    always_comb begin
        next_state = state;
        imem_req   = 1'b0;
        HOLD       = 1'b1;
        dmem_req   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run) next_state = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req   = 1'b1;
                next_state = ST_WAIT_I;
            end
            ST_WAIT_I: begin
                imem_req = 1'b1;
                if (imem_valid) next_state = ST_DECODE;
            end
            ST_DECODE: begin
                HOLD       = 1'b0;
                next_state = ST_EXEC;
            end
            ST_EXEC: begin
                if (is_mem)   next_state = ST_MEM;
                else if (run) next_state = ST_FETCH;
                else          next_state = ST_IDLE;
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                if (dmem_ack) next_state = run ? ST_FETCH : ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Next-PC decode from the instruction register; T_word is deliberately ignored
    always_comb begin
        pc_next = pc_inc;
        if (is_bsr) begin
            pc_next = bsr_target;
        end else if (is_ret) begin
            pc_next = empty ? pc_inc : stack_top;
        end else begin
            case (opcode)
                OP_JUMP: pc_next = jump_target;
                OP_JZE:  pc_next = flag_z  ? jump_target : pc_inc;
                OP_JNE:  pc_next = !flag_z ? jump_target : pc_inc;
                OP_JCY:  pc_next = flag_cy ? jump_target : pc_inc;
                default: pc_next = pc_inc;
            endcase
        end
    end

    // Instruction register loads once per fetch, when memory answers in WAIT_I
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instruction <= '0;
        end else if (state == ST_WAIT_I && imem_valid) begin
            instruction <= imem_data;
        end
    end

    // PC and sticky stack error update at the end of EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= '0;
            stack_err <= 1'b0;
        end else if (in_exec) begin
            pc        <= pc_next;
            stack_err <= stack_err | err_event;
        end
    end

endmodule

// File: tb/tb_uinstr_sequencer.sv
module tb_uinstr_sequencer;

   localparam int PC_W  = 11;
   localparam int DEPTH = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            run;
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_valid;
   logic [21:0]     imem_data;
   logic [21:0]     instruction;
   logic            HOLD;
   logic [32:0]     micro_instruction;
   logic            flag_z;
   logic            flag_cy;
   logic            dmem_req;
   logic            dmem_ack;
   logic [PC_W-1:0] pc;
   logic            stack_err;

   uinstr_sequencer #(.PC_W(PC_W), .STACK_DEPTH(DEPTH)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .run               (run),
      .imem_req          (imem_req),
      .imem_addr         (imem_addr),
      .imem_valid        (imem_valid),
      .imem_data         (imem_data),
      .instruction       (instruction),
      .HOLD              (HOLD),
      .micro_instruction (micro_instruction),
      .flag_z            (flag_z),
      .flag_cy           (flag_cy),
      .dmem_req          (dmem_req),
      .dmem_ack          (dmem_ack),
      .pc                (pc),
      .stack_err         (stack_err)
   );

   // 10-unit clock period
   always #5 clk = ~clk;

   typedef struct {
      int unsigned addr;
      bit          err;
      int          cycles;
      int          memCycles;
   } exp_t;

   exp_t        sbQueue[$];
   int          passCount  = 0;
   int          totalCount = 0;
   bit          monitorOn  = 1'b0;
   bit          aborted    = 1'b0;

   // Reference model state: architectural PC, return stack as a queue, sticky error
   int unsigned modelPc    = 0;
   int unsigned modelStack[$];
   bit          modelErr   = 1'b0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      totalCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   // Architectural effect of one instruction on PC and the return stack
   function automatic void modelStep(input logic [21:0] ins, input bit fz, input bit fcy);
      int unsigned target;
      int unsigned nxt;
      target = int'(ins[10:0]);
      nxt    = (modelPc + 1) % (1 << PC_W);
      if (ins[21:10] == 12'h700) begin
         if (modelStack.size() < DEPTH) modelStack.push_back(nxt);
         else modelErr = 1'b1;
         modelPc = int'(ins[9:0]);
      end else if (ins == 22'h060000) begin
         if (modelStack.size() > 0) modelPc = modelStack.pop_back();
         else begin
            modelErr = 1'b1;
            modelPc  = nxt;
         end
      end else begin
         case (ins[21:19])
            3'b100:  modelPc = target;
            3'b101:  modelPc = fz  ? target : nxt;
            3'b110:  modelPc = !fz ? target : nxt;
            3'b111:  modelPc = fcy ? target : nxt;
            default: modelPc = nxt;
         endcase
      end
   endfunction

   // Monitor: on every new fetch request, pop the expected result and compare
   initial begin
      int   cyc;
      int   holdLow;
      int   memHigh;
      bit   prevReq;
      exp_t e;
      cyc = 0; holdLow = 0; memHigh = 0; prevReq = 1'b0;
      forever begin
         @(negedge clk);
         if (monitorOn) begin
            cyc++;
            if (!HOLD) holdLow++;
            if (dmem_req) memHigh++;
            if (imem_req && !prevReq) begin
               if (sbQueue.size() == 0) begin
                  checkOutput("unexpected_fetch", 32'd1, 32'd0);
               end else begin
                  e = sbQueue.pop_front();
                  checkOutput("fetch_addr", 32'(imem_addr), e.addr);
                  checkOutput("stack_err", 32'(stack_err), 32'(e.err));
                  if (e.cycles >= 0) begin
                     checkOutput("instr_cycles", cyc, e.cycles);
                     checkOutput("hold_low_cycles", holdLow, 32'd1);
                     checkOutput("dmem_req_cycles", memHigh, e.memCycles);
                  end
               end
               cyc = 0; holdLow = 0; memHigh = 0;
            end
         end
         prevReq = imem_req;
      end
   end

   task automatic waitFetch(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (imem_req) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Plays program memory, ROM and data memory for one instruction
   task automatic applyStimulus(input logic [21:0] instr, input bit fz, input bit fcy,
                                input bit mem, input int d, input int k, input bit dropRun);
      bit   ok;
      exp_t e;
      logic [31:0] r;
      waitFetch(ok);
      if (!ok) begin
         checkOutput("fetch_timeout", 32'd0, 32'd1);
         aborted = 1'b1;
         return;
      end
      // FETCH: junk response and ack must both be ignored here
      r          = $urandom;
      imem_valid = 1'b1;
      imem_data  = r[21:0];
      dmem_ack   = 1'b0;
      flag_z     = r[22];
      flag_cy    = r[23];
      @(negedge clk);
      imem_valid = 1'b0;
      repeat (d) @(negedge clk);
      r                     = $urandom;
      imem_valid            = 1'b1;
      imem_data             = instr;
      flag_z                = fz;
      flag_cy               = fcy;
      micro_instruction     = {r, 1'b0};
      micro_instruction[25] = mem & r[0];
      micro_instruction[24] = mem & ~r[0];
      modelStep(instr, fz, fcy);
      e.addr      = modelPc;
      e.err       = modelErr;
      e.cycles    = dropRun ? -1 : 4 + d + (mem ? k : 0);
      e.memCycles = mem ? k : 0;
      sbQueue.push_back(e);
      @(negedge clk);
      imem_valid = 1'b0;
      imem_data  = 22'h3FFFFF;
      checkOutput("instruction_reg", 32'(instruction), 32'(instr));
      if (dropRun) run = 1'b0;
      @(negedge clk);
      dmem_ack = 1'b1;
      if (mem) begin
         for (int i = 1; i <= k; i++) begin
            @(negedge clk);
            dmem_ack = (i == k);
         end
      end
   endtask

   initial begin
      logic [21:0] ins;
      logic [31:0] r;
      int          cat;
      int          cnt;
      bit          ok;
      exp_t        e;

      rst_n = 1'b0; run = 1'b0; imem_valid = 1'b0; imem_data = '0;
      micro_instruction = '0; flag_z = 1'b0; flag_cy = 1'b0; dmem_ack = 1'b0;
      #12;
      checkOutput("rst_HOLD", 32'(HOLD), 32'd1);
      checkOutput("rst_imem_req", 32'(imem_req), 32'd0);
      checkOutput("rst_dmem_req", 32'(dmem_req), 32'd0);
      checkOutput("rst_pc", 32'(pc), 32'd0);
      checkOutput("rst_instruction", 32'(instruction), 32'd0);
      checkOutput("rst_stack_err", 32'(stack_err), 32'd0);

      e.addr = 0; e.err = 1'b0; e.cycles = -1; e.memCycles = 0;
      sbQueue.push_back(e);
      monitorOn = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      run   = 1'b1;

      // Directed program walk
      applyStimulus(22'h0AAAAA, 0, 0, 0, 0, 0, 0);
      applyStimulus(22'h200123, 0, 0, 0, 0, 0, 0);
      applyStimulus(22'h280040, 1, 0, 0, 0, 0, 0);
      applyStimulus(22'h280040, 0, 0, 0, 1, 0, 0);
      applyStimulus(22'h200005, 0, 0, 0, 0, 0, 0);
      applyStimulus(22'h1C0010, 0, 0, 0, 0, 0, 0);
      applyStimulus(22'h060000, 0, 0, 0, 0, 0, 0);
      applyStimulus(22'h1C0020, 0, 0, 0, 0, 0, 0);
      applyStimulus(22'h1C0030, 0, 0, 0, 0, 0, 0);
      applyStimulus(22'h1C0040, 0, 0, 0, 0, 0, 0);
      applyStimulus(22'h1C0050, 0, 0, 0, 0, 0, 0);
      applyStimulus(22'h1C0060, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) applyStimulus(22'h060000, 0, 0, 0, 0, 0, 0);
      applyStimulus(22'h0AAAAA, 0, 0, 1, 0, 3, 0);
      applyStimulus(22'h2807FF, 1, 1, 0, 2, 0, 0);

      // Randomised instruction mix
      for (int i = 0; i < 80 && !aborted; i++) begin
         r   = $urandom;
         cat = $urandom_range(0, 8);
         case (cat)
            3:       ins = {3'b100, r[18:0]};
            4:       ins = {3'b101, r[18:0]};
            5:       ins = {3'b110, r[18:0]};
            6:       ins = {3'b111, r[18:0]};
            7:       ins = {12'h700, r[9:0]};
            8:       ins = 22'h060000;
            default: begin
               ins = {2'b00, r[19:0]};
               if (ins == 22'h060000) ins = 22'h060001;
            end
         endcase
         applyStimulus(ins, r[20], r[21], ($urandom_range(0, 3) == 0),
                       $urandom_range(0, 2), $urandom_range(1, 3), 0);
      end

      if (!aborted) begin
         // run drops in DECODE: instruction completes, then sequencer parks
         applyStimulus(22'h200321, 0, 0, 0, 0, 0, 1);
         cnt = 0;
         repeat (6) begin
            @(negedge clk);
            if (imem_req) cnt++;
         end
         checkOutput("idle_no_fetch", cnt, 32'd0);
         checkOutput("idle_pc", 32'(pc), modelPc);
         run = 1'b1;
         applyStimulus(22'h000100, 0, 0, 0, 0, 0, 0);
      end

      if (!aborted) begin
         // Reset pulse in WAIT_I aborts the fetch asynchronously
         waitFetch(ok);
         if (!ok) checkOutput("fetch_timeout", 32'd0, 32'd1);
         @(negedge clk);
         monitorOn = 1'b0;
         checkOutput("pre_rst_in_wait_i", 32'(imem_req), 32'd1);
         rst_n = 1'b0;
         #1;
         checkOutput("wait_rst_imem_req", 32'(imem_req), 32'd0);
         checkOutput("wait_rst_pc", 32'(pc), 32'd0);
         checkOutput("wait_rst_HOLD", 32'(HOLD), 32'd1);
         checkOutput("wait_rst_stack_err", 32'(stack_err), 32'd0);
         checkOutput("wait_rst_instruction", 32'(instruction), 32'd0);
         checkOutput("scoreboard_drained", sbQueue.size(), 32'd0);
      end

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule

// File: doc/uinstr_sequencer.md
# uinstr_sequencer

Fetch/decode/execute sequencer for the microcoded CPU. It fetches 22-bit instructions from program memory and holds them on the instruction input of the microinstruction ROM. It gates the ROM with `HOLD`, resolves jumps, calls and returns through a small return stack, and stalls execution on data-memory reads and writes until acknowledged. It sits between program memory, the microinstruction ROM, and the datapath flag register.

## Interface
- `PC_W`, default 11: program counter width; all jump and call targets are zero-extended to it.
- `STACK_DEPTH`, default 4: number of return-stack entries (power of two, 2 to 16).
- `clk` in, 1: single clock. Sequencer logic is posedge; the ROM samples on negedge.
- `rst_n` in, 1: asynchronous, active-low reset.
- `run` in, 1: sampled in IDLE; 1 starts or continues fetching.
- `imem_req` out, 1: program memory read request.
- `imem_addr` out, PC_W: fetch address, equal to `pc`.
- `imem_valid` in, 1: `imem_data` is valid this cycle.
- `imem_data` in, 22: fetched instruction.
- `instruction` out, 22: instruction register, driven to the ROM.
- `HOLD` out, 1: 0 only in DECODE; the ROM updates only while `HOLD` is 0.
- `micro_instruction` in, 33: ROM output. Fields: ALU[32:29], SH[28:27], Kmx[26], MR[25], MW[24], Bus_B[23:18], Bus_C[17:12], T_word[11:5], Bus_A[4:0].
- `flag_z` in, 1: datapath zero flag.
- `flag_cy` in, 1: datapath carry flag.
- `dmem_req` out, 1: data memory access in progress.
- `dmem_ack` in, 1: data memory access complete.
- `pc` out, PC_W: program counter.
- `stack_err` out, 1: sticky return-stack overflow/underflow indication, cleared only by reset.

## Operation
- States: IDLE, FETCH, WAIT_I, DECODE, EXEC, MEM.
- IDLE → FETCH when `run`=1.
- FETCH: `imem_req`=1 for one cycle, then go to WAIT_I.
- WAIT_I: hold `imem_req`=1. On `imem_valid`, load `instruction` from `imem_data` and go to DECODE.
- DECODE: `HOLD`=0 for exactly one cycle. Go to EXEC.
- EXEC: apply the next-PC rule below.
  - If MR or MW is set in `micro_instruction`, go to MEM.
  - Otherwise go to FETCH if `run`=1, else IDLE.
- MEM: `dmem_req`=1 until `dmem_ack`. Then go to FETCH if `run`=1, else IDLE.
- Next-PC is decoded by the sequencer from `instruction`, never from T_word:
  - `[21:19]`=100 (JUMP): pc ← `[10:0]`.
  - 101 (JZE): pc ← `[10:0]` if `flag_z`=1, else pc+1.
  - 110 (JNE): pc ← `[10:0]` if `flag_z`=0, else pc+1.
  - 111 (JCY): pc ← `[10:0]` if `flag_cy`=1, else pc+1.
  - `[21:10]`=0111_0000_0000 (BSR): push pc+1 and set pc ← `[9:0]`. If the stack is full: no push, `stack_err`←1, pc still jumps.
  - `instruction`=22'h060000 (RET): pop into pc. If the stack is empty: `stack_err`←1 and pc ← pc+1.
  - Any other instruction: pc ← pc+1.
- PC arithmetic is modulo 2^PC_W; the maximum value wraps to 0.
- Flags are sampled in EXEC.
- Reset values: state IDLE, `pc`=0, `instruction`=0, `HOLD`=1, `imem_req`=0, `dmem_req`=0, `stack_err`=0, stack pointer 0.
- Reset asserted in any state, including WAIT_I or MEM, aborts the access immediately. All outputs take their reset values asynchronously.

## Timing
- Minimum instruction time is 4 cycles: FETCH, WAIT_I (with `imem_valid` on its first cycle), DECODE, EXEC.
- A memory instruction adds at least 1 MEM cycle, with `dmem_ack` in the first MEM cycle.
- `instruction` is stable from the posedge entering DECODE. The ROM negedge inside DECODE produces `micro_instruction`, which is valid at the EXEC posedge.
- `imem_valid` is ignored outside WAIT_I. `dmem_ack` is ignored outside MEM.
- The new `pc` is visible the cycle after EXEC, which is the FETCH cycle.
- `run` dropping mid-instruction completes the current instruction, then the sequencer parks in IDLE.

## Structure
- Shared package `cpu_pkg` holds:
  - Opcode prefix constants: JUMP, JZE, JNE, JCY, BSR, RET.
  - Microinstruction field bit ranges.
  - State enum.
- One sub-module, `ret_stack`: LIFO of STACK_DEPTH entries, PC_W bits wide, with push/pop, full/empty outputs, and async active-low reset.

## Test plan
- Reset, then `run`=1, memory returns 22'h0AAAAA at address 0 → `HOLD` low for exactly 1 cycle, `pc`=1 after EXEC, 4 cycles per instruction.
- JUMP 22'h200123 → next `imem_addr`=11'h123.
- JZE 22'h280040: with `flag_z`=1 → pc=11'h040; with `flag_z`=0 → pc+1.
- BSR to 0x010 at pc=5, then RET → pc=16, then pc=6. Five nested BSRs with STACK_DEPTH=4 → `stack_err`=1, and the 4 returns yield the correct addresses.
- MR set in `micro_instruction`, `dmem_ack` delayed 3 cycles → `dmem_req` high for 3 cycles, then FETCH.
- `rst_n` pulsed low during WAIT_I → `imem_req`=0, `pc`=0, `HOLD`=1 within the same cycle.
